// File: rtl/bullet_fire_controller_if.sv
// rtl/bullet_fire_controller_if.sv - shared direction type and controller/entity signal bundle
//
// bullet_fire_pkg : DIRECTION type shared with tank and bullet entity logic.
// bullet_fire_controller_if : every non-clock signal of one bullet slot.
//   master : tank/input logic and bullet entity side (drives the inputs)
//   slave  : bullet_fire_controller side (drives spawn/bounce/kill controls)

package bullet_fire_pkg;
  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } direction_t;
endpackage

interface bullet_fire_controller_if;
  import bullet_fire_pkg::*;

  // shooter / target / entity inputs
  logic        fireBtn;
  direction_t  tankDir;
  logic [31:0] tankPosX;
  logic [31:0] tankPosY;
  logic [31:0] targetPosX;
  logic [31:0] targetPosY;
  logic        bulletExists;
  logic [31:0] bulletPosX;
  logic [31:0] bulletPosY;

  // entity controls and status
  logic        sigSpawn;
  logic        sigBounce;
  logic        sigKill;
  direction_t  bulletStartDir;
  logic [31:0] bulletStartX;
  logic [31:0] bulletStartY;
  logic [7:0]  bulletStep;
  logic [7:0]  bulletLife;
  logic        hitTarget;
  logic        ready;

  modport master (
    output fireBtn, tankDir, tankPosX, tankPosY, targetPosX, targetPosY,
           bulletExists, bulletPosX, bulletPosY,
    input  sigSpawn, sigBounce, sigKill, bulletStartDir, bulletStartX,
           bulletStartY, bulletStep, bulletLife, hitTarget, ready
  );

  modport slave (
    input  fireBtn, tankDir, tankPosX, tankPosY, targetPosX, targetPosY,
           bulletExists, bulletPosX, bulletPosY,
    output sigSpawn, sigBounce, sigKill, bulletStartDir, bulletStartX,
           bulletStartY, bulletStep, bulletLife, hitTarget, ready
  );
endinterface

// File: rtl/bullet_fire_controller.sv
// rtl/bullet_fire_controller.sv - per-slot bullet spawn/bounce/kill sequencer
//
// Ports:
//   frameClk : frame clock (one edge per video frame)
//   reset    : synchronous active-high reset
//   bus      : bullet_fire_controller_if.slave
//              inputs  fireBtn, tankDir, tankPos*, targetPos*, bulletExists, bulletPos*
//              outputs sigSpawn, sigBounce, sigKill, bulletStart*, bulletStep,
//                      bulletLife, hitTarget, ready

module bullet_fire_controller
  import bullet_fire_pkg::*;
#(
  parameter int ARENA_MIN_X     = 0,
  parameter int ARENA_MAX_X     = 639,
  parameter int ARENA_MIN_Y     = 0,
  parameter int ARENA_MAX_Y     = 479,
  parameter int MUZZLE_OFFSET   = 16,
  parameter int HIT_RADIUS      = 8,
  parameter int BULLET_STEP     = 4,
  parameter int BULLET_LIFE     = 3,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int BOUNCE_GUARD    = 2
) (
  input logic                     frameClk,
  input logic                     reset,
  bullet_fire_controller_if.slave bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SPAWN    = 3'd1;
  localparam logic [2:0] ARM      = 3'd2;
  localparam logic [2:0] FLIGHT   = 3'd3;
  localparam logic [2:0] COOLDOWN = 3'd4;

  localparam int GW = (BOUNCE_GUARD > 0) ? $clog2(BOUNCE_GUARD + 1) : 1;
  localparam int CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  localparam logic [31:0]        MUZZLE  = 32'(MUZZLE_OFFSET);
  localparam logic signed [32:0] HIT_LIM = 33'(HIT_RADIUS);

  logic [2:0]    state;
  logic          fire_q;
  logic          arm_cnt;
  logic [GW-1:0] guard_cnt;
  logic [CW-1:0] cool_cnt;

  logic          spawn_q;
  logic          bounce_q;
  logic          kill_q;
  logic          hit_q;
  logic          ready_q;
  direction_t    start_dir;
  logic [31:0]   start_x;
  logic [31:0]   start_y;

  logic                fire_edge;
  logic signed [32:0]  dx;
  logic signed [32:0]  dy;
  logic signed [31:0]  bx;
  logic signed [31:0]  by;
  logic                target_hit;
  logic                wall_hit;

  assign fire_edge = bus.fireBtn & ~fire_q;

  // Sign-extend to 33 bits so the subtraction cannot overflow.
  assign dx = $signed({bus.bulletPosX[31], bus.bulletPosX})
            - $signed({bus.targetPosX[31], bus.targetPosX});
  assign dy = $signed({bus.bulletPosY[31], bus.bulletPosY})
            - $signed({bus.targetPosY[31], bus.targetPosY});

  assign target_hit = (dx < HIT_LIM) && (dx > -HIT_LIM) &&
                      (dy < HIT_LIM) && (dy > -HIT_LIM);

  assign bx = $signed(bus.bulletPosX);
  assign by = $signed(bus.bulletPosY);

  assign wall_hit = (bx <= ARENA_MIN_X) || (bx >= ARENA_MAX_X) ||
                    (by <= ARENA_MIN_Y) || (by >= ARENA_MAX_Y);

  always_ff @(posedge frameClk) begin
    if (reset) begin
      state     <= IDLE;
      fire_q    <= 1'b0;
      arm_cnt   <= 1'b0;
      guard_cnt <= '0;
      cool_cnt  <= '0;
      spawn_q   <= 1'b0;
      bounce_q  <= 1'b0;
      kill_q    <= 1'b0;
      hit_q     <= 1'b0;
      ready_q   <= 1'b1;
      start_dir <= RIGHT;
      start_x   <= '0;
      start_y   <= '0;
    end else begin
      // fire_q tracks the button in every state, so a press held through
      // flight and cooldown never looks like a fresh edge back in IDLE.
      fire_q   <= bus.fireBtn;
      spawn_q  <= 1'b0;
      bounce_q <= 1'b0;
      kill_q   <= 1'b0;
      hit_q    <= 1'b0;

      // Pulses and ready are registered against the state being entered,
      // so they are visible during the frame that state occupies.
      case (state)
        IDLE: begin
          if (fire_edge) begin
            start_dir <= bus.tankDir;
            start_x   <= bus.tankPosX;
            start_y   <= bus.tankPosY;
            case (bus.tankDir)
              UP:      start_y <= bus.tankPosY - MUZZLE;
              DOWN:    start_y <= bus.tankPosY + MUZZLE;
              LEFT:    start_x <= bus.tankPosX - MUZZLE;
              default: start_x <= bus.tankPosX + MUZZLE;
            endcase
            state   <= SPAWN;
            spawn_q <= 1'b1;
            ready_q <= 1'b0;
          end
        end

        SPAWN: begin
          state   <= ARM;
          arm_cnt <= 1'b0;
        end

        ARM: begin
          if (bus.bulletExists) begin
            state     <= FLIGHT;
            guard_cnt <= '0;
          end else if (arm_cnt) begin
            // Entity never came up after two frames: treat as a spent bullet.
            state    <= COOLDOWN;
            cool_cnt <= CW'(COOLDOWN_FRAMES);
          end else begin
            arm_cnt <= 1'b1;
          end
        end

        FLIGHT: begin
          if (!bus.bulletExists) begin
            state    <= COOLDOWN;
            cool_cnt <= CW'(COOLDOWN_FRAMES);
          end else if (target_hit) begin
            kill_q   <= 1'b1;
            hit_q    <= 1'b1;
            state    <= COOLDOWN;
            cool_cnt <= CW'(COOLDOWN_FRAMES);
          end else if (wall_hit && guard_cnt == '0) begin
            bounce_q  <= 1'b1;
            guard_cnt <= GW'(BOUNCE_GUARD);
          end else if (guard_cnt != '0) begin
            // The entity keeps moving outward on the bounce frame, so the
            // bullet is still past the wall for a couple of frames.
            guard_cnt <= guard_cnt - GW'(1);
          end
        end

        COOLDOWN: begin
          if (cool_cnt == '0) begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end else begin
            cool_cnt <= cool_cnt - CW'(1);
          end
        end

        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.sigSpawn       = spawn_q;
  assign bus.sigBounce      = bounce_q;
  assign bus.sigKill        = kill_q;
  assign bus.hitTarget      = hit_q;
  assign bus.ready          = ready_q;
  assign bus.bulletStartDir = start_dir;
  assign bus.bulletStartX   = start_x;
  assign bus.bulletStartY   = start_y;
  assign bus.bulletStep     = 8'(BULLET_STEP);
  assign bus.bulletLife     = 8'(BULLET_LIFE);

endmodule

// File: tb/tb_bullet_fire_controller.sv
// tb/tb_bullet_fire_controller.sv - scoreboard bench for bullet_fire_controller

module tb_bullet_fire_controller;
  import bullet_fire_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bullet_fire_controller_if bus();

  bullet_fire_controller dut (
    .frameClk (clk),
    .reset    (reset),
    .bus      (bus)
  );

  typedef struct {
    int          kind;   // 0 spawn, 1 bounce, 2 kill
    int          frame;
    logic [31:0] sx;
    logic [31:0] sy;
    direction_t  dir;
    logic        hit;
  } ev_t;

  ev_t exp_q[$];

  logic [31:0] m_sx;
  logic [31:0] m_sy;
  direction_t  m_dir;

  // Monitor: every pulse frame must match the oldest expected event.
  always @(negedge clk) begin
    ev_t e;
    int  kind;
    int  npulse;
    while (exp_q.size() > 0 && exp_q[0].frame < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_event: kind=%0d want frame %0d, none by frame %0d", e.kind, e.frame, cyc);
    end
    npulse = int'(bus.sigSpawn) + int'(bus.sigBounce) + int'(bus.sigKill);
    if (npulse > 1) begin
      checks++;
      errors++;
      $display("FAIL multi_pulse: frame %0d got %0d pulses want at most 1", cyc, npulse);
    end
    if (bus.hitTarget && !bus.sigKill) begin
      checks++;
      errors++;
      $display("FAIL hit_without_kill: frame %0d got hitTarget=1 sigKill=0 want both", cyc);
    end
    if (npulse > 0) begin
      kind = bus.sigSpawn ? 0 : (bus.sigBounce ? 1 : 2);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: frame %0d got kind=%0d want none", cyc, kind);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != kind || e.frame != cyc || e.sx != bus.bulletStartX ||
            e.sy != bus.bulletStartY || e.dir != bus.bulletStartDir ||
            e.hit != bus.hitTarget) begin
          errors++;
          $display("FAIL event: got kind=%0d frame=%0d sx=%0h sy=%0h dir=%0d hit=%0b want kind=%0d frame=%0d sx=%0h sy=%0h dir=%0d hit=%0b",
                   kind, cyc, bus.bulletStartX, bus.bulletStartY, bus.bulletStartDir, bus.hitTarget,
                   e.kind, e.frame, e.sx, e.sy, e.dir, e.hit);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Pulse expected on the next edge after the current inputs are sampled.
  task automatic expect_ev(input int kind, input logic hit);
    ev_t e;
    e.kind  = kind;
    e.frame = cyc + 1;
    e.sx    = m_sx;
    e.sy    = m_sy;
    e.dir   = m_dir;
    e.hit   = hit;
    exp_q.push_back(e);
  endtask

  task automatic fire(input direction_t d, input logic [31:0] tx, input logic [31:0] ty,
                      input logic [31:0] ex, input logic [31:0] ey);
    bus.fireBtn = 1'b0;
    tick();
    bus.tankDir  = d;
    bus.tankPosX = tx;
    bus.tankPosY = ty;
    bus.fireBtn  = 1'b1;
    m_sx  = ex;
    m_sy  = ey;
    m_dir = d;
    expect_ev(0, 1'b0);
    tick();
    chk("spawn_ready_low", 32'(bus.ready), 32'd0);
    chk("spawn_start_x", bus.bulletStartX, ex);
    chk("spawn_start_y", bus.bulletStartY, ey);
    chk("spawn_start_dir", 32'(bus.bulletStartDir), 32'(d));
  endtask

  initial begin
    int xs[5];
    xs = '{636, 640, 644, 640, 636};

    reset            = 1'b1;
    bus.fireBtn      = 1'b0;
    bus.tankDir      = UP;
    bus.tankPosX     = 32'd0;
    bus.tankPosY     = 32'd0;
    bus.targetPosX   = 32'd2000;
    bus.targetPosY   = 32'd2000;
    bus.bulletExists = 1'b0;
    bus.bulletPosX   = 32'd300;
    bus.bulletPosY   = 32'd240;
    tick(2);

    chk("reset_ready", 32'(bus.ready), 32'd1);
    chk("reset_start_x", bus.bulletStartX, 32'd0);
    chk("reset_start_y", bus.bulletStartY, 32'd0);
    chk("reset_start_dir", 32'(bus.bulletStartDir), 32'(RIGHT));
    chk("reset_pulses", {29'd0, bus.sigSpawn, bus.sigBounce, bus.sigKill}, 32'd0);
    chk("const_step", 32'(bus.bulletStep), 32'd4);
    chk("const_life", 32'(bus.bulletLife), 32'd3);
    reset = 1'b0;
    tick();

    // Spawn to the right, then a right-wall bounce followed by guard frames.
    fire(RIGHT, 32'd100, 32'd200, 32'd116, 32'd200);
    bus.bulletExists = 1'b1;
    bus.bulletPosX   = 32'd600;
    bus.bulletPosY   = 32'd240;
    tick(4);
    for (int i = 0; i < 5; i++) begin
      bus.bulletPosX = 32'(xs[i]);
      if (i == 1) expect_ev(1, 1'b0);
      tick();
    end
    // Guard expired: bottom wall bounces again.
    bus.bulletPosX = 32'd300;
    bus.bulletPosY = 32'd479;
    expect_ev(1, 1'b0);
    tick();
    bus.bulletPosY = 32'd240;
    tick();

    // Near misses on the hitbox edge, then a real hit.
    bus.targetPosX = 32'd308;
    bus.targetPosY = 32'd240;
    tick(2);
    bus.targetPosX = 32'd292;
    tick(2);
    bus.targetPosX = 32'd300;
    bus.targetPosY = 32'd248;
    tick(2);
    bus.targetPosX = 32'd305;
    bus.targetPosY = 32'd245;
    expect_ev(2, 1'b1);
    tick();
    chk("hit_kill", {30'd0, bus.sigKill, bus.hitTarget}, 32'd3);
    bus.bulletExists = 1'b0;
    tick(30);
    chk("hit_cooldown_ready_low", 32'(bus.ready), 32'd0);
    tick();
    chk("hit_cooldown_ready_high", 32'(bus.ready), 32'd1);
    tick(3);
    chk("held_btn_no_refire", 32'(bus.ready), 32'd1);

    // Corner contact with the target inside the hitbox: kill wins over bounce.
    fire(UP, 32'd50, 32'd60, 32'd50, 32'd44);
    bus.bulletExists = 1'b1;
    bus.bulletPosX   = 32'd100;
    bus.bulletPosY   = 32'd100;
    bus.targetPosX   = 32'd2;
    bus.targetPosY   = 32'd2;
    tick(4);
    bus.bulletPosX = 32'd0;
    bus.bulletPosY = 32'd0;
    expect_ev(2, 1'b1);
    tick();
    chk("corner_no_bounce", 32'(bus.sigBounce), 32'd0);
    bus.bulletExists = 1'b0;
    tick(30);
    chk("corner_ready_low", 32'(bus.ready), 32'd0);
    tick();
    chk("corner_ready_high", 32'(bus.ready), 32'd1);

    // Wrapping muzzle position; entity disappears mid-flight.
    fire(LEFT, 32'd10, 32'd10, 32'hFFFF_FFFA, 32'd10);
    bus.bulletExists = 1'b1;
    bus.bulletPosX   = 32'd200;
    bus.bulletPosY   = 32'd200;
    bus.targetPosX   = 32'd2000;
    bus.targetPosY   = 32'd2000;
    tick(4);
    bus.bulletExists = 1'b0;
    tick(31);
    chk("drop_ready_low", 32'(bus.ready), 32'd0);
    tick();
    chk("drop_ready_high", 32'(bus.ready), 32'd1);
    tick(3);
    chk("drop_held_no_refire", 32'(bus.ready), 32'd1);

    // Entity never appears: ARM gives up after two frames.
    fire(DOWN, 32'd100, 32'd100, 32'd100, 32'd116);
    tick(2);
    chk("arm_ready_low", 32'(bus.ready), 32'd0);
    tick(31);
    chk("arm_timeout_ready_low", 32'(bus.ready), 32'd0);
    tick();
    chk("arm_timeout_ready_high", 32'(bus.ready), 32'd1);

    // Reset during flight with the bullet on the wall.
    fire(DOWN, 32'd200, 32'd300, 32'd200, 32'd316);
    bus.bulletExists = 1'b1;
    bus.bulletPosX   = 32'd400;
    bus.bulletPosY   = 32'd240;
    tick(4);
    reset          = 1'b1;
    bus.fireBtn    = 1'b0;
    bus.bulletPosX = 32'd639;
    tick();
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_dir", 32'(bus.bulletStartDir), 32'(RIGHT));
    chk("rst_start_x", bus.bulletStartX, 32'd0);
    chk("rst_start_y", bus.bulletStartY, 32'd0);
    chk("rst_pulses", {29'd0, bus.sigSpawn, bus.sigBounce, bus.sigKill}, 32'd0);
    reset            = 1'b0;
    bus.bulletExists = 1'b0;
    tick(2);
    @(negedge clk);
    #1;
    chk("events_left", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bullet_fire_controller.md
Name: bullet_fire_controller

Overview:
- Drives a bullet entity's control inputs: `sigSpawn`, `sigBounce`, `sigKill`, start position and direction, step, and life.
- Watches the entity's `bulletExists` and position outputs to detect arena-wall bounces and hits on a target tank.
- Sits between tank/input logic and one bullet entity; one instance per bullet slot.
- Clocked once per video frame.

Parameters:
- ARENA_MIN_X, 0, left wall x; a bullet at or left of it bounces.
- ARENA_MAX_X, 639, right wall x; a bullet at or right of it bounces.
- ARENA_MIN_Y, 0, top wall y.
- ARENA_MAX_Y, 479, bottom wall y.
- MUZZLE_OFFSET, 16, spawn distance from the tank centre along the tank's facing.
- HIT_RADIUS, 8, half-width of the square target hitbox.
- BULLET_STEP, 4, pixels per frame, driven on `bulletStep`.
- BULLET_LIFE, 3, bounces allowed, driven on `bulletLife`.
- COOLDOWN_FRAMES, 30, frames after a bullet ends before the next fire is accepted.
- BOUNCE_GUARD, 2, frames after a bounce during which further bounces are suppressed.

Ports:
- frameClk  in  1  frame clock
- reset  in  1  synchronous, active-high reset
- fireBtn  in  1  fire request (level); acted on at its rising edge
- tankDir  in  DIRECTION  shooter facing, using the shared DIRECTION type (UP/DOWN/LEFT/RIGHT)
- tankPosX, tankPosY  in  32 each  shooter centre
- targetPosX, targetPosY  in  32 each  target tank centre
- bulletExists  in  1  from the bullet entity
- bulletPosX, bulletPosY  in  32 each  current bullet position, from the entity
- sigSpawn  out  1  one-frame spawn pulse
- sigBounce  out  1  one-frame bounce pulse
- sigKill  out  1  one-frame kill pulse
- bulletStartDir  out  DIRECTION  latched spawn direction
- bulletStartX, bulletStartY  out  32 each  latched spawn position
- bulletStep  out  8  constant BULLET_STEP
- bulletLife  out  8  constant BULLET_LIFE
- hitTarget  out  1  one-frame pulse, coincident with sigKill on a hit
- ready  out  1  high in IDLE only

Behaviour:
- All outputs are registered, except the constant `bulletStep`/`bulletLife`.
- Reset values:
  - state = IDLE
  - all pulses 0
  - `bulletStartX`/`bulletStartY` = 0, `bulletStartDir` = RIGHT
  - guard and cooldown counters = 0
  - `fireBtn` edge register = 0
- Reset mid-flight forces IDLE on the next edge. No `sigKill` is issued; the entity receives the same reset.
- Fire detect: `fireEdge = fireBtn & ~fireBtn_q`. It is ignored outside IDLE and is not queued.
- IDLE:
  - on `fireEdge`, latch `bulletStartDir = tankDir`.
  - latch the start position as tank position +/- MUZZLE_OFFSET along `tankDir`: UP subtracts from Y, DOWN adds to Y, LEFT subtracts from X, RIGHT adds to X.
  - 32-bit wrap arithmetic, no clamping.
  - next state SPAWN.
- SPAWN: `sigSpawn` = 1 for exactly this frame; next state ARM.
- ARM:
  - wait for `bulletExists` = 1, then go to FLIGHT.
  - if it is still 0 after 2 frames in ARM, go to COOLDOWN (spawn failed).
- FLIGHT, evaluated each frame in this priority:
  1. `bulletExists` = 0 → COOLDOWN, no pulses (life expired or external kill).
  2. Hit: |bulletPosX - targetPosX| < HIT_RADIUS and |bulletPosY - targetPosY| < HIT_RADIUS, using signed 33-bit differences. Result: `sigKill` = 1 and `hitTarget` = 1 for one frame, then COOLDOWN. A hit in the same frame as a wall contact gives kill only, no bounce.
  3. Wall contact with guard counter = 0. Wall contact means X <= ARENA_MIN_X, X >= ARENA_MAX_X, Y <= ARENA_MIN_Y or Y >= ARENA_MAX_Y, signed compare. Result: `sigBounce` = 1 for one frame and guard counter = BOUNCE_GUARD.
  4. Guard counter > 0 → decrement it; no bounce is issued even if still out of bounds.
- Why the guard: the entity moves one more step in the old direction on the bounce frame, so the bullet stays out of bounds for 2 frames after the bounce.
- COOLDOWN:
  - counter loads COOLDOWN_FRAMES on entry and decrements each frame.
  - exit to IDLE when the counter reaches 0 (COOLDOWN_FRAMES+1 frames in COOLDOWN).
  - `fireBtn` held high through COOLDOWN does not fire on return to IDLE; a new rising edge is needed.
- At most one of `sigSpawn`/`sigBounce`/`sigKill` is high in any frame.

Test Plan:
- Reset, tank (100,200) RIGHT, `fireBtn` 0→1 → `sigSpawn` high exactly 1 frame, one frame after the edge; `bulletStartX`=116, `bulletStartY`=200, `bulletStartDir`=RIGHT; `ready` falls.
- FLIGHT, `bulletPosX` steps 636→640→644 → `sigBounce` on the 640 frame only; none on 644, which is within the guard.
- Bullet (300,240), target (305,245) → `sigKill` and `hitTarget` one frame, then COOLDOWN. Target at (308,240) → no kill (|dx|=8, not < 8).
- Bullet at (0,0) with target (2,2) → `sigKill` only, `sigBounce` stays 0.
- `bulletExists` drops in FLIGHT → no pulses; `ready` returns after 31 frames. `fireBtn` held high throughout → no spawn until it is released and pressed again.
- `reset` asserted in FLIGHT → next frame: IDLE, `ready`=1, all pulses 0, `bulletStartDir`=RIGHT.
